// File: rtl/mem_pkg.sv
// mem_pkg: shared region map, access-width and fault-cause encodings for the load/store path.
package mem_pkg;
    localparam logic [15:0] ROM_REGION  = 16'h0000;
    localparam logic [15:0] MMIO_REGION = 16'h7000;
    localparam logic [15:0] RAM_REGION  = 16'h8000;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_UNMAPPED  = 2'd1,
        FC_ROM_STORE = 2'd2,
        FC_FUNCT3    = 2'd3
    } fault_cause_t;

    // An access is misaligned when it crosses a 32-bit word boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return (funct3[1:0] == 2'b01 && addr == 2'b11) || (funct3[1:0] == 2'b10 && addr != 2'b00);
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: sign/zero-extends right-aligned read data according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    always_comb
        o_data = i_funct3 == MW_B  ? {{24{i_data[7]}}, i_data[7:0]}
               : i_funct3 == MW_H  ? {{16{i_data[15]}}, i_data[15:0]}
               : i_funct3 == MW_BU ? {24'b0, i_data[7:0]}
               : i_funct3 == MW_HU ? {16'b0, i_data[15:0]}
               : i_data;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: checks and issues one load/store per cycle to the data memory port,
// tracks the outstanding load across split accesses and registers writeback, faults and event counts.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_address,
    input  logic [31:0]        req_store_data,
    input  logic [4:0]         req_rd,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               fault_valid,
    output logic [1:0]         fault_cause,
    output logic [31:0]        fault_address,
    output logic [COUNT_W-1:0] cnt_loads,
    output logic [COUNT_W-1:0] cnt_stores,
    output logic [COUNT_W-1:0] cnt_misaligned,
    output logic [COUNT_W-1:0] cnt_stall_cycles,
    output logic [31:0]        dmem_address,
    output logic               dmem_enable,
    output logic [31:0]        dmem_write_data,
    output logic               dmem_write_enable,
    output logic [2:0]         dmem_write_mode,
    output logic               dmem_read_enable,
    output logic [2:0]         dmem_read_mode,
    input  logic [31:0]        dmem_read_data,
    input  logic               dmem_wait
);
    logic        w_accept, w_issue, w_fault, w_misaligned, w_return;
    logic [1:0]  w_cause;
    logic [15:0] w_region;
    logic [31:0] w_ext;
    logic        r_pend_valid;
    logic [2:0]  r_pend_funct3;
    logic [4:0]  r_pend_rd;

    load_extend u_extend (.i_data(dmem_read_data), .i_funct3(r_pend_funct3), .o_data(w_ext));

    always_comb begin
        req_ready = !dmem_wait && !reset;
        w_accept = req_valid && req_ready;
        w_region = req_address[31:16];
        w_cause = (!(req_funct3 inside {MW_B, MW_H, MW_W, MW_BU, MW_HU}) || (req_is_store && req_funct3[2])) ? FC_FUNCT3
                : !(w_region inside {ROM_REGION, MMIO_REGION, RAM_REGION}) ? FC_UNMAPPED
                : (req_is_store && w_region == ROM_REGION) ? FC_ROM_STORE : FC_NONE;
        w_fault = w_accept && w_cause != FC_NONE;
        w_issue = w_accept && w_cause == FC_NONE;
        w_misaligned = is_misaligned(req_funct3, req_address[1:0]);
        w_return = r_pend_valid && !dmem_wait;
        dmem_enable = w_issue;
        dmem_write_enable = w_issue && req_is_store;
        dmem_read_enable = w_issue && !req_is_store;
        dmem_address = w_issue ? req_address : '0;
        dmem_write_data = w_issue ? req_store_data : '0;
        dmem_write_mode = w_issue ? req_funct3 : '0;
        dmem_read_mode = w_issue ? req_funct3 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_funct3 <= '0;
            r_pend_rd <= '0;
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            fault_valid <= 1'b0;
            fault_cause <= '0;
            fault_address <= '0;
            cnt_loads <= '0;
            cnt_stores <= '0;
            cnt_misaligned <= '0;
            cnt_stall_cycles <= '0;
        end else begin
            wb_valid <= w_return;
            if (w_return) begin
                wb_rd <= r_pend_rd;
                wb_data <= w_ext;
            end
            // A load accepted in the return cycle takes over the pending slot directly.
            if (w_issue && !req_is_store) begin
                r_pend_valid <= 1'b1;
                r_pend_funct3 <= req_funct3;
                r_pend_rd <= req_rd;
            end else if (w_return) begin
                r_pend_valid <= 1'b0;
            end
            fault_valid <= w_fault;
            if (w_fault) begin
                fault_cause <= w_cause;
                fault_address <= req_address;
            end
            if (w_issue && !req_is_store) cnt_loads <= cnt_loads + COUNT_W'(1);
            if (w_issue && req_is_store) cnt_stores <= cnt_stores + COUNT_W'(1);
            if (w_issue && w_misaligned) cnt_misaligned <= cnt_misaligned + COUNT_W'(1);
            if (req_valid && !req_ready) cnt_stall_cycles <= cnt_stall_cycles + COUNT_W'(1);
        end
    end
endmodule
